// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller for uart_receiver. Sequences the receiver enable
// and baud code through a small FSM (OFF -> LOAD -> RUN, with RECONF on a
// baud change). While in RUN it pushes good frames into a show-ahead FIFO
// that the consumer drains through a valid/ready port. Errored frames are
// dropped. A good frame that arrives while the FIFO is full sets a sticky
// overflow flag.
//
// Optional feature macro: UART_RX_ERRCNT_EN
//   defined   -> saturating framing/parity error counters
//   undefined -> ferr_count/perr_count tied to 8'h00
//
// Ports
//   clock, reset         : system clock (rising edge), async active-low reset
//   enable, baud_cfg     : software receive request and requested baud code
//   Rx_DATA/VALID/FERROR/PERROR : receiver status levels
//   Rx_EN, baud_select   : registered receiver controls
//   out_data/valid/ready : FIFO head, consumer handshake
//   fifo_level           : registered occupancy, 0..DEPTH
//   overflow             : sticky good-frame-dropped flag
//   clear_status         : clears overflow (and the counters when present)
//   ferr_count/perr_count: error counters
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [2:0]    baud_cfg,
  input  logic [7:0]    Rx_DATA,
  input  logic          Rx_VALID,
  input  logic          Rx_FERROR,
  input  logic          Rx_PERROR,
  output logic          Rx_EN,
  output logic [2:0]    baud_select,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  input  logic          clear_status,
  output logic [7:0]    ferr_count,
  output logic [7:0]    perr_count
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // ---------------------------------------------------------------------
  // Control FSM. Outputs are registered and updated on the transition into
  // each state, so baud_select takes the new code on entry to LOAD and
  // Rx_EN rises on entry to RUN.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {S_OFF, S_LOAD, S_RUN, S_RECONF} state_e;

  state_e     state_q;
  logic       rx_en_q;
  logic [2:0] baud_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_OFF;
      rx_en_q <= 1'b0;
      baud_q  <= 3'b000;
    end else begin
      case (state_q)
        S_OFF: begin
          rx_en_q <= 1'b0;
          if (enable) begin
            state_q <= S_LOAD;
            baud_q  <= baud_cfg;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
          rx_en_q <= 1'b1;
        end
        S_RUN: begin
          // Disable wins over a pending baud change.
          if (!enable) begin
            state_q <= S_OFF;
            rx_en_q <= 1'b0;
          end else if (baud_cfg != baud_q) begin
            state_q <= S_RECONF;
            rx_en_q <= 1'b0;
          end
        end
        S_RECONF: begin
          rx_en_q <= 1'b0;
          if (!enable) begin
            state_q <= S_OFF;
          end else begin
            state_q <= S_LOAD;
            baud_q  <= baud_cfg;
          end
        end
        default: begin
          state_q <= S_OFF;
          rx_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign Rx_EN       = rx_en_q;
  assign baud_select = baud_q;

  // ---------------------------------------------------------------------
  // Edge detection. The edge registers track their inputs in every state;
  // only the use of the edges is gated by RUN.
  // ---------------------------------------------------------------------
  logic vld_q, err_q;
  logic err, run, vld_rise, err_rise, push;

  assign err      = Rx_FERROR | Rx_PERROR;
  assign run      = (state_q == S_RUN);
  assign vld_rise = Rx_VALID & ~vld_q;
  assign err_rise = err & ~err_q;
  assign push     = run & vld_rise & ~err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= Rx_VALID;
      err_q <= err;
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead circular FIFO. Pointers are AW bits and wrap naturally since
  // DEPTH is a power of two; occupancy is tracked separately so full and
  // empty are unambiguous.
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, do_push, drop;

  assign full      = (level_q == FULL_LVL);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Sticky flag: a new drop in the same cycle beats the clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_status) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (do_push) mem_q[wptr_q] <= Rx_DATA;
    end
  end

  assign out_data   = out_valid ? mem_q[rptr_q] : 8'h00;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

  // ---------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------
`ifdef UART_RX_ERRCNT_EN
  logic [7:0] ferr_q, ferr_d, perr_q, perr_d;
  logic       ferr_inc, perr_inc;

  assign ferr_inc = run & err_rise & Rx_FERROR;
  assign perr_inc = run & err_rise & Rx_PERROR;

  // An increment in the same cycle as clear_status wins over the clear.
  always_comb begin
    ferr_d = ferr_q;
    perr_d = perr_q;
    if (clear_status) begin
      ferr_d = 8'h00;
      perr_d = 8'h00;
    end
    if (ferr_inc) ferr_d = (ferr_q == 8'hFF) ? 8'hFF : ferr_q + 8'h01;
    if (perr_inc) perr_d = (perr_q == 8'hFF) ? 8'hFF : perr_q + 8'h01;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ferr_q <= 8'h00;
      perr_q <= 8'h00;
    end else begin
      ferr_q <= ferr_d;
      perr_q <= perr_d;
    end
  end

  assign ferr_count = ferr_q;
  assign perr_count = perr_q;
`else
  assign ferr_count = 8'h00;
  assign perr_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Good frames push their byte onto a
// scoreboard queue when driven; the queue front is compared whenever the
// consumer pops the FIFO head.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef UART_RX_ERRCNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    baud_cfg = 3'd0;
  logic [7:0]    Rx_DATA = 8'h00;
  logic          Rx_VALID = 1'b0, Rx_FERROR = 1'b0, Rx_PERROR = 1'b0;
  logic          out_ready = 1'b0, clear_status = 1'b0;
  logic          Rx_EN, out_valid, overflow;
  logic [2:0]    baud_select;
  logic [7:0]    out_data, ferr_count, perr_count;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .baud_cfg(baud_cfg),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR),
    .Rx_PERROR(Rx_PERROR), .Rx_EN(Rx_EN), .baud_select(baud_select),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .clear_status(clear_status),
    .ferr_count(ferr_count), .perr_count(perr_count)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One receiver frame: VALID high for one edge, then low for one edge.
  task automatic frame(input logic [7:0] d, input bit expect_push);
    Rx_DATA = d; Rx_VALID = 1'b1;
    if (expect_push) sb.push_back(d);
    tick();
    Rx_VALID = 1'b0; Rx_DATA = 8'h00;
    tick();
  endtask

  task automatic go_run(input logic [2:0] b);
    baud_cfg = b; enable = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL reset_rxen got %0b exp 0", Rx_EN); end
    checks++; if (baud_select !== 3'd0) begin errors++; $display("FAIL reset_baud got %0d exp 0", baud_select); end
    checks++; if ({out_valid, out_data, fifo_level, overflow} !== '0) begin errors++;
      $display("FAIL reset_fifo got v%0b d%0h l%0d o%0b exp zeros", out_valid, out_data, fifo_level, overflow); end
    checks++; if ({ferr_count, perr_count} !== 16'h0) begin errors++;
      $display("FAIL reset_cnt got %0h/%0h exp 0/0", ferr_count, perr_count); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_enable;
    enable = 1'b1; baud_cfg = 3'd5;
    tick();
    checks++; if (baud_select !== 3'd5 || Rx_EN !== 1'b0) begin errors++;
      $display("FAIL enable_load got baud %0d en %0b exp 5/0", baud_select, Rx_EN); end
    tick();
    checks++; if (Rx_EN !== 1'b1 || baud_select !== 3'd5) begin errors++;
      $display("FAIL enable_run got en %0b baud %0d exp 1/5", Rx_EN, baud_select); end
  endtask

  task automatic test_capture;
    Rx_DATA = 8'hA5; Rx_VALID = 1'b1; sb.push_back(8'hA5);
    tick();
    Rx_VALID = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== sb[0] || fifo_level !== 3'd1) begin errors++;
      $display("FAIL capture got v%0b d%0h l%0d exp 1/%0h/1", out_valid, out_data, fifo_level, sb[0]); end
    exp_b = sb.pop_front();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin errors++;
      $display("FAIL capture_pop got l%0d v%0b d%0h exp 0/0/00", fifo_level, out_valid, out_data); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) frame(8'(i), i <= 4);
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_full got l%0d o%0b exp 4/1", fifo_level, overflow); end
    for (int k = 0; k < 4; k++) begin
      exp_b = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin errors++;
        $display("FAIL ovf_drain%0d got v%0b d%0h exp 1/%0h", k, out_valid, out_data, exp_b); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (fifo_level !== 3'd0 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_empty got l%0d o%0b exp 0/1", fifo_level, overflow); end
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
    // Refill, then push the 5th byte in the same cycle as a pop.
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1);
    exp_b = sb.pop_front();
    checks++; if (out_data !== exp_b) begin errors++; $display("FAIL ovf_head got %0h exp %0h", out_data, exp_b); end
    Rx_DATA = 8'h05; Rx_VALID = 1'b1; out_ready = 1'b1; sb.push_back(8'h05);
    tick();
    Rx_VALID = 1'b0; out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_pushpop got l%0d exp 4", fifo_level); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_none got %0b exp 0", overflow); end
    for (int k = 0; k < 4; k++) begin
      exp_b = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin errors++;
        $display("FAIL ovf_drainb%0d got v%0b d%0h exp 1/%0h", k, out_valid, out_data, exp_b); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin errors++;
      $display("FAIL ovf_final got v%0b left %0d exp 0/0", out_valid, sb.size()); end
  endtask

  task automatic test_errors;
    Rx_DATA = 8'h3C; Rx_VALID = 1'b1; Rx_FERROR = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL err_nopush got l%0d v%0b exp 0/0", fifo_level, out_valid); end
    checks++; if (ferr_count !== (CNT ? 8'd1 : 8'd0) || perr_count !== 8'd0) begin errors++;
      $display("FAIL err_ferr got %0d/%0d exp %0d/0", ferr_count, perr_count, CNT ? 1 : 0); end
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0;
    tick();
    Rx_VALID = 1'b1; Rx_FERROR = 1'b1; Rx_PERROR = 1'b1;
    tick();
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    checks++; if (ferr_count !== (CNT ? 8'd2 : 8'd0) || perr_count !== (CNT ? 8'd1 : 8'd0)) begin errors++;
      $display("FAIL err_both got %0d/%0d exp %0d/%0d", ferr_count, perr_count, CNT ? 2 : 0, CNT ? 1 : 0); end
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    checks++; if (ferr_count !== 8'd0 || perr_count !== 8'd0 || fifo_level !== 3'd0) begin errors++;
      $display("FAIL err_clear got %0d/%0d l%0d exp 0/0/0", ferr_count, perr_count, fifo_level); end
    frame(8'h5A, 1'b1);
    exp_b = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin errors++;
      $display("FAIL err_recover got v%0b d%0h exp 1/%0h", out_valid, out_data, exp_b); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reconf;
    baud_cfg = 3'd2;
    tick();
    checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd5) begin errors++;
      $display("FAIL reconf_gap1 got en %0b baud %0d exp 0/5", Rx_EN, baud_select); end
    Rx_DATA = 8'h77; Rx_VALID = 1'b1;
    tick();
    Rx_VALID = 1'b0;
    checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd2) begin errors++;
      $display("FAIL reconf_gap2 got en %0b baud %0d exp 0/2", Rx_EN, baud_select); end
    tick();
    checks++; if (Rx_EN !== 1'b1 || baud_select !== 3'd2 || fifo_level !== 3'd0) begin errors++;
      $display("FAIL reconf_run got en %0b baud %0d l%0d exp 1/2/0", Rx_EN, baud_select, fifo_level); end
  endtask

  task automatic test_disable_priority;
    enable = 1'b0; baud_cfg = 3'd6;
    tick();
    checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd2) begin errors++;
      $display("FAIL dis_prio got en %0b baud %0d exp 0/2", Rx_EN, baud_select); end
    tick(2);
    checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd2) begin errors++;
      $display("FAIL dis_off got en %0b baud %0d exp 0/2", Rx_EN, baud_select); end
    frame(8'h99, 1'b0);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL dis_nocap got l%0d exp 0", fifo_level); end
  endtask

  task automatic test_reset_mid_run;
    go_run(3'd3);
    frame(8'hC3, 1'b1);
    frame(8'h3C, 1'b1);
    checks++; if (Rx_EN !== 1'b1 || fifo_level !== 3'd2) begin errors++;
      $display("FAIL mid_pre got en %0b l%0d exp 1/2", Rx_EN, fifo_level); end
    #2 reset = 1'b0;
    #1;
    sb.delete();
    checks++; if ({Rx_EN, baud_select, out_valid, out_data, fifo_level, overflow} !== '0) begin errors++;
      $display("FAIL mid_reset got en%0b b%0d v%0b d%0h l%0d o%0b exp zeros",
               Rx_EN, baud_select, out_valid, out_data, fifo_level, overflow); end
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (Rx_EN !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_after got en %0b v%0b exp 0/0", Rx_EN, out_valid); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_capture();
    test_overflow();
    test_errors();
    test_reconf();
    test_disable_priority();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
